hazard_unit_v2: RTL and testbench

- Next-generation hazard detection and forwarding unit for the pipelined mMIPS core; sits beside the ID stage and drives PC, IF/ID, ID/EX-bubble and memory enables.
- Generalises the previous unit with parametrised register-address width and branch-resolution latency.
- Adds EX/MEM-over-MEM/WB forwarding priority, a load-use stall, a registered branch-wait counter and a memory-wait state machine.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_fwd_sel.sv | 24 ++
 rtl/hazard_unit_v2.sv | 156 +++++++++++++++
 tb/tb_hazard_unit_v2.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared FSM state, forwarding-select codes and branch opcodes for the hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd2;
  localparam logic [1:0] FWD_MEMWB = 2'd3;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational operand-source select: EX/MEM result beats MEM/WB, register 0 never forwards.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_exmem_regwrite,
  input  logic [REG_AW-1:0] i_exmem_wreg,
  input  logic              i_memwb_regwrite,
  input  logic [REG_AW-1:0] i_memwb_wreg,
  output logic [1:0]        o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_exmem_regwrite && (i_exmem_wreg == i_src) && (i_exmem_wreg != '0)) begin
      o_fwd = FWD_EXMEM;
    end else if (i_memwb_regwrite && (i_memwb_wreg == i_src) && (i_memwb_wreg != '0)) begin
      o_fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_unit_v2.sv
// Hazard/forwarding unit: combinational enables and forwarding, registered branch-wait/memory-wait FSM.
// Optional performance counters are compiled in with HAZARD_UNIT_PERF_EN.
module hazard_unit_v2
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int BRANCH_LAT = 1
`ifdef HAZARD_UNIT_PERF_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              dmem_wait,
  input  logic              imem_wait,
  input  logic [31:0]       id_instr,
  input  logic [1:0]        id_branch_op,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_wreg,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_wreg,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_wreg,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              bubble,
  output logic              pipe_en,
  output logic              imem_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZARD_UNIT_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  branch_bubbles,
  output logic [CNT_W-1:0]  loaduse_stalls
`endif
);

  hz_state_t         r_state, w_state_nxt;
  logic [2:0]        r_brc, w_brc_nxt;
  logic [REG_AW-1:0] w_rs, w_rt;
  logic [1:0]        w_fwd_a, w_fwd_b;
  logic              w_wait, w_load_use, w_lu_stall, w_br_bub;
  logic              w_unused;

  assign w_rs     = REG_AW'(id_instr[25:21]);
  assign w_rt     = REG_AW'(id_instr[20:16]);
  assign w_unused = ^id_instr[15:0];
  assign w_wait   = dmem_wait | imem_wait;

  assign w_load_use = idex_regwrite && idex_memread && (idex_wreg != '0) &&
                      ((idex_wreg == w_rs) || (idex_wreg == w_rt));

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs (
    .i_src(w_rs), .i_exmem_regwrite(exmem_regwrite), .i_exmem_wreg(exmem_wreg),
    .i_memwb_regwrite(memwb_regwrite), .i_memwb_wreg(memwb_wreg), .o_fwd(w_fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rt (
    .i_src(w_rt), .i_exmem_regwrite(exmem_regwrite), .i_exmem_wreg(exmem_wreg),
    .i_memwb_regwrite(memwb_regwrite), .i_memwb_wreg(memwb_wreg), .o_fwd(w_fwd_b)
  );

  assign fwd_a = rst ? w_fwd_a : FWD_RF;
  assign fwd_b = rst ? w_fwd_b : FWD_RF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_brc   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_brc   <= w_brc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_brc_nxt   = r_brc;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    bubble      = 1'b0;
    pipe_en     = 1'b0;
    imem_en     = 1'b0;
    w_lu_stall  = 1'b0;
    w_br_bub    = 1'b0;
    if (rst && enable) begin
      case (r_state)
        // MEM_WAIT with both waits clear decides exactly like RUN, so no cycle is lost on exit.
        RUN, MEM_WAIT: begin
          if (w_wait) begin
            w_state_nxt = MEM_WAIT;
            imem_en     = !dmem_wait;
          end else begin
            w_state_nxt = RUN;
            if (id_branch_op != 2'b00) begin
              bubble    = 1'b1;
              pc_write  = 1'b1;
              imem_en   = 1'b1;
              pipe_en   = 1'b1;
              w_br_bub  = 1'b1;
              w_brc_nxt = 3'(BRANCH_LAT - 1);
              if (BRANCH_LAT > 1) w_state_nxt = BR_WAIT;
            end else if (w_load_use) begin
              bubble     = 1'b1;
              pipe_en    = 1'b1;
              w_lu_stall = 1'b1;
            end else if ((id_instr[31:26] == OP_BEQ) || (id_instr[31:26] == OP_BNE)) begin
              ifid_write = 1'b1;
              pipe_en    = 1'b1;
            end else begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
              pipe_en    = 1'b1;
              imem_en    = 1'b1;
            end
          end
        end
        BR_WAIT: begin
          bubble = 1'b1;
          if (!w_wait) begin
            pipe_en   = 1'b1;
            w_br_bub  = 1'b1;
            w_brc_nxt = r_brc - 3'd1;
            if (r_brc == 3'd1) w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

`ifdef HAZARD_UNIT_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles, r_branch_bubbles, r_loaduse_stalls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles   <= '0;
      r_branch_bubbles <= '0;
      r_loaduse_stalls <= '0;
    end else begin
      if (enable && !pc_write && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_br_bub && (r_branch_bubbles != '1)) r_branch_bubbles <= r_branch_bubbles + 1'b1;
      if (w_lu_stall && (r_loaduse_stalls != '1)) r_loaduse_stalls <= r_loaduse_stalls + 1'b1;
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign branch_bubbles = r_branch_bubbles;
  assign loaduse_stalls = r_loaduse_stalls;
`endif

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed self-checking bench for hazard_unit_v2 (BRANCH_LAT = 3).
module tb_hazard_unit_v2;

  logic        clk = 1'b0;
  logic        rst, enable, dmem_wait, imem_wait;
  logic [31:0] id_instr;
  logic [1:0]  id_branch_op;
  logic        idex_regwrite, idex_memread, exmem_regwrite, memwb_regwrite;
  logic [4:0]  idex_wreg, exmem_wreg, memwb_wreg;
  logic        pc_write, ifid_write, bubble, pipe_en, imem_en;
  logic [1:0]  fwd_a, fwd_b;
`ifdef HAZARD_UNIT_PERF_EN
  logic [15:0] stall_cycles, branch_bubbles, loaduse_stalls;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_unit_v2 #(.REG_AW(5), .BRANCH_LAT(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dmem_wait(dmem_wait), .imem_wait(imem_wait),
    .id_instr(id_instr), .id_branch_op(id_branch_op),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_wreg(idex_wreg),
    .exmem_regwrite(exmem_regwrite), .exmem_wreg(exmem_wreg),
    .memwb_regwrite(memwb_regwrite), .memwb_wreg(memwb_wreg),
    .pc_write(pc_write), .ifid_write(ifid_write), .bubble(bubble), .pipe_en(pipe_en),
    .imem_en(imem_en), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_UNIT_PERF_EN
    , .stall_cycles(stall_cycles), .branch_bubbles(branch_bubbles), .loaduse_stalls(loaduse_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {pc_write, ifid_write, pipe_en, imem_en, bubble}
  function automatic logic [4:0] outs();
    return {pc_write, ifid_write, pipe_en, imem_en, bubble};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  task automatic cyc(input string tag, input logic [4:0] exp);
    #1;
    check(tag, 32'(outs()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b1; dmem_wait = 1'b0; imem_wait = 1'b0;
    id_instr = 32'h0; id_branch_op = 2'b00;
    idex_regwrite = 1'b0; idex_memread = 1'b0; idex_wreg = 5'd0;
    exmem_regwrite = 1'b0; exmem_wreg = 5'd0;
    memwb_regwrite = 1'b0; memwb_wreg = 5'd0;
  endtask

  task automatic set_load_use();
    idex_regwrite = 1'b1; idex_memread = 1'b1; idex_wreg = 5'd9;
    id_instr = mk(6'd0, 5'd1, 5'd9);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    id_instr = mk(6'd0, 5'd8, 5'd0);
    exmem_regwrite = 1'b1; exmem_wreg = 5'd8;
    #2;
    check("rst_outs", 32'(outs()), 32'h0);
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    idle();
    cyc("run_idle", 5'b11110);

    // forwarding priority
    id_instr = mk(6'd0, 5'd8, 5'd0);
    exmem_regwrite = 1'b1; exmem_wreg = 5'd8; memwb_regwrite = 1'b1; memwb_wreg = 5'd8;
    #1; check("fwd_exmem", 32'(fwd_a), 32'd2); check("fwd_b_none", 32'(fwd_b), 32'd0);
    exmem_regwrite = 1'b0;
    #1; check("fwd_memwb", 32'(fwd_a), 32'd3);
    exmem_regwrite = 1'b1; id_instr = mk(6'd0, 5'd0, 5'd0); exmem_wreg = 5'd0; memwb_wreg = 5'd0;
    #1; check("fwd_r0", 32'(fwd_a), 32'd0);
    id_instr = mk(6'd0, 5'd8, 5'd5); exmem_wreg = 5'd8; memwb_wreg = 5'd5;
    #1; check("fwd_a_split", 32'(fwd_a), 32'd2); check("fwd_b_split", 32'(fwd_b), 32'd3);
    idle();

    // load-use: one stall, then forwarded from EX/MEM
    set_load_use();
    cyc("loaduse", 5'b00101);
    idex_regwrite = 1'b0; idex_memread = 1'b0; exmem_regwrite = 1'b1; exmem_wreg = 5'd9;
    #1; check("lu_fwd_b", 32'(fwd_b), 32'd2);
    cyc("lu_after", 5'b11110);
    idle();

    // branch together with load-use: branch wins, 3 bubble cycles
    set_load_use(); id_branch_op = 2'b01;
    cyc("br_c0", 5'b10111);
    idle();
    cyc("br_c1", 5'b00101); cyc("br_c2", 5'b00101); cyc("br_done", 5'b11110);

    // memory wait inside BR_WAIT freezes the count
    id_branch_op = 2'b10; cyc("brw_c0", 5'b10111);
    id_branch_op = 2'b00; dmem_wait = 1'b1;
    cyc("brw_frz0", 5'b00001); cyc("brw_frz1", 5'b00001);
    dmem_wait = 1'b0;
    cyc("brw_c1", 5'b00101); cyc("brw_c2", 5'b00101); cyc("brw_done", 5'b11110);

    // enable low holds BR_WAIT
    id_branch_op = 2'b01; cyc("en_c0", 5'b10111);
    id_branch_op = 2'b00; enable = 1'b0;
    cyc("en0_a", 5'b00000); cyc("en0_b", 5'b00000);
    enable = 1'b1;
    cyc("en_c1", 5'b00101); cyc("en_c2", 5'b00101); cyc("en_done", 5'b11110);

    // data and instruction memory waits from RUN
    dmem_wait = 1'b1;
    for (int i = 0; i < 4; i++) cyc("dwait", 5'b00000);
    dmem_wait = 1'b0; cyc("dwait_end", 5'b11110);
    imem_wait = 1'b1;
    for (int i = 0; i < 4; i++) cyc("iwait", 5'b00010);
    imem_wait = 1'b0; cyc("iwait_end", 5'b11110);

    // wait beats branch; branch taken on the exit cycle
    dmem_wait = 1'b1; id_branch_op = 2'b01; cyc("wait_vs_br", 5'b00000);
    dmem_wait = 1'b0; cyc("br_after_wait", 5'b10111);
    idle();
    cyc("baw_c1", 5'b00101); cyc("baw_c2", 5'b00101); cyc("baw_done", 5'b11110);

    // beq/bne opcode in ID without a decoded branch_op
    id_instr = mk(6'b000100, 5'd1, 5'd2); cyc("beq_id", 5'b01100);
    id_instr = mk(6'b000101, 5'd1, 5'd2); cyc("bne_id", 5'b01100);
    idle();

    // asynchronous reset in the middle of BR_WAIT
    id_branch_op = 2'b01; cyc("rb_c0", 5'b10111);
    id_branch_op = 2'b00;
    rst = 1'b0;
    #1; check("rst_mid_br", 32'(outs()), 32'h0);
    @(posedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cyc("post_rst_run", 5'b11110);

`ifdef HAZARD_UNIT_PERF_EN
    set_load_use(); cyc("p_lu1", 5'b00101);
    idle(); cyc("p_run1", 5'b11110);
    set_load_use(); cyc("p_lu2", 5'b00101);
    idle(); cyc("p_run2", 5'b11110);
    id_branch_op = 2'b01; cyc("p_br0", 5'b10111);
    idle(); cyc("p_br1", 5'b00101); cyc("p_br2", 5'b00101);
    #1;
    check("perf_loaduse", 32'(loaduse_stalls), 32'd2);
    check("perf_branch", 32'(branch_bubbles), 32'd3);
    check("perf_stall", 32'(stall_cycles), 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
